// File: rtl/rvvi_pkg.sv
// Shared definitions for the RVVI transmit scheduler slice.
// Optional feature macro: RVVI_TX_TIMEOUT_EN (host-acknowledge watchdog).
package rvvi_pkg;

  // Scheduler FSM encoding; also presented on the debug state output.
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } txState_e;

  // Width of the inter-frame gap down-counter (GAP_CYCLES is 0..255).
  localparam int GAP_CNT_W = 8;

  // A transfer completes on the MAC side when both valid and ready are high.
  function automatic logic isTxHandshake(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/rvvi_tx_scheduler_if.sv
// Bundle of the RVVI scheduler's frame-source, MAC and host signals.
// Optional feature macro: RVVI_TX_TIMEOUT_EN (drives TimeoutReq when defined).
//
// Handshake semantics: on the Tx side a frame moves exactly on a rising edge
// where TxValid and TxReady are both high; once TxValid is raised, TxData and
// TxIsReplay stay stable and TxValid stays high until that edge. On the source
// side, a frame is taken on an edge where its valid is high and its stall
// (LiveStall / RVVIStall) is low; a stalled source must hold its frame.
interface rvvi_tx_scheduler_if #(
  parameter int WIDTH = 792
);
  logic             LiveValid;
  logic [WIDTH-1:0] LiveData;
  logic             LiveStall;
  logic             ReplayValid;
  logic [WIDTH-1:0] ReplayData;
  logic             RVVIStall;
  logic             ReplayBusy;
  logic             HostAck;
  logic             TxValid;
  logic [WIDTH-1:0] TxData;
  logic             TxReady;
  logic             TxIsReplay;
  logic             TimeoutReq;

  // Scheduler side.
  modport master (
    input  LiveValid, LiveData, ReplayValid, ReplayData, ReplayBusy,
           HostAck, TxReady,
    output LiveStall, RVVIStall, TxValid, TxData, TxIsReplay, TimeoutReq
  );

  // Core / active list / MAC / host side.
  modport slave (
    output LiveValid, LiveData, ReplayValid, ReplayData, ReplayBusy,
           HostAck, TxReady,
    input  LiveStall, RVVIStall, TxValid, TxData, TxIsReplay, TimeoutReq
  );
endinterface

// File: rtl/rvvi_tx_watchdog.sv
// Host-acknowledge watchdog: counts cycles a transmitted frame waits for
// HostAck and pulses timeoutReq when the counter reaches all-ones.
// Only instantiated when RVVI_TX_TIMEOUT_EN is defined.
module rvvi_tx_watchdog #(
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic txFire,
  input  logic hostAck,
  output logic timeoutReq
);

  logic                     outstanding;
  logic [TIMEOUT_WIDTH-1:0] wdCnt;

  // A frame is outstanding from its Tx handshake until the next HostAck;
  // a new handshake in the same cycle as an ack starts a fresh wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= 1'b0;
    end else if (txFire) begin
      outstanding <= 1'b1;
    end else if (hostAck) begin
      outstanding <= 1'b0;
    end
  end

  // Cleared while idle or on ack; otherwise free-runs and wraps past all-ones.
  always_ff @(posedge clk) begin
    if (reset || hostAck || !outstanding) begin
      wdCnt <= '0;
    end else begin
      wdCnt <= wdCnt + TIMEOUT_WIDTH'(1);
    end
  end

  // Counter only leaves zero while a frame is outstanding, so all-ones
  // lasts exactly one cycle before wrapping.
  assign timeoutReq = outstanding & (&wdCnt);

endmodule

// File: rtl/rvvi_tx_scheduler.sv
// RVVI transmit scheduler: merges live core frames and replay frames onto a
// single valid/ready link to the MAC, replay first, with a fixed idle gap
// between frames.
// Optional feature macro: RVVI_TX_TIMEOUT_EN adds the host-ack watchdog
// (rvvi_tx_watchdog) driving TimeoutReq; otherwise TimeoutReq is tied low.
module rvvi_tx_scheduler
  import rvvi_pkg::*;
#(
  parameter int WIDTH         = 792,
  parameter int GAP_CYCLES    = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rvvi_tx_scheduler_if.master  bus,
  output logic [1:0]           dbgState
);

  localparam logic [1:0] IDLE = TX_IDLE;
  localparam logic [1:0] SEND = TX_SEND;
  localparam logic [1:0] GAP  = TX_GAP;

  // The gap counter is loaded with GAP_CYCLES-1 so GAP lasts GAP_CYCLES cycles.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  logic [1:0]           state;
  logic [GAP_CNT_W-1:0] gapCnt;
  logic [WIDTH-1:0]     txData;
  logic                 txValid;
  logic                 txIsReplay;

  logic isIdle;
  logic replayAccept;
  logic liveAccept;
  logic txFire;

  assign isIdle       = (state == IDLE);
  // Replay wins any tie; live frames additionally wait out a busy active list.
  assign replayAccept = isIdle & bus.ReplayValid;
  assign liveAccept   = isIdle & ~bus.ReplayValid & bus.LiveValid & ~bus.ReplayBusy;
  assign txFire       = isTxHandshake(txValid, bus.TxReady);

  // Scheduler FSM with the Tx output register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gapCnt     <= '0;
      txData     <= '0;
      txValid    <= 1'b0;
      txIsReplay <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (replayAccept) begin
            txData     <= bus.ReplayData;
            txIsReplay <= 1'b1;
            txValid    <= 1'b1;
            state      <= SEND;
          end else if (liveAccept) begin
            txData     <= bus.LiveData;
            txIsReplay <= 1'b0;
            txValid    <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (txFire) begin
            txValid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              gapCnt <= GAP_LOAD;
              state  <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gapCnt == '0) begin
            state <= IDLE;
          end else begin
            gapCnt <= gapCnt - GAP_CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          txValid <= 1'b0;
        end
      endcase
    end
  end

  // Sources may only hand over a frame while the scheduler sits in IDLE
  // (and not while reset is held).
  assign bus.RVVIStall = reset | ~isIdle;
  assign bus.LiveStall = reset | ~isIdle | bus.ReplayValid | bus.ReplayBusy;

  assign bus.TxValid    = txValid;
  assign bus.TxData     = txData;
  assign bus.TxIsReplay = txIsReplay;
  assign dbgState       = state;

`ifdef RVVI_TX_TIMEOUT_EN
  rvvi_tx_watchdog #(
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .txFire    (txFire),
    .hostAck   (bus.HostAck),
    .timeoutReq(bus.TimeoutReq)
  );
`else
  // No watchdog in this build: HostAck and TIMEOUT_WIDTH are intentionally unused.
  logic unusedTimeout;
  assign unusedTimeout  = bus.HostAck & (TIMEOUT_WIDTH != 0);
  assign bus.TimeoutReq = 1'b0;
`endif

endmodule
